// File: rtl/fir_delay_ctrl.sv
// Runtime-programmable sample delay line for the FIR front end.
// Ring buffer indexed by sample count; output held invalid while a new delay refills.
module fir_delay_ctrl #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned MAX_DELAY     = 64,
    parameter int unsigned DEFAULT_DELAY = 8,
    localparam int unsigned DW = $clog2(MAX_DELAY + 1),
    localparam int unsigned AW = $clog2(MAX_DELAY)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    input  logic [DW-1:0]         cfg_delay_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    output logic [DATA_WIDTH-1:0] delay_data_o,
    output logic                  delay_valid_o,
    output logic [DW-1:0]         cur_delay_o,
    output logic                  filling_o,
    output logic                  cfg_sat_o
);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D   = DW'(DEFAULT_DELAY);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DELAY - 1);
    localparam logic [DW:0]   MAX_W   = (DW+1)'(MAX_DELAY);
    localparam state_t        RST_STATE = (DEFAULT_DELAY == 0) ? RUN : FILL;

    logic [DATA_WIDTH-1:0] mem [MAX_DELAY];

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [DW-1:0]         cur_delay_q, cur_delay_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sat_q, sat_d;
    logic                  ready_q, filling_q;
    logic [DW:0]           rd_sum_c;
    logic [AW-1:0]         rd_addr_c;
    logic [DW-1:0]         cfg_clamp_c;
    logic                  accept_c;

    // Sample history; intentionally not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (src_valid_i) begin
            mem[wr_ptr_q] <= src_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RST_STATE;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            cur_delay_q <= DEF_D;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sat_q       <= 1'b0;
            ready_q     <= (RST_STATE == RUN);
            filling_q   <= (RST_STATE == FILL);
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            cur_delay_q <= cur_delay_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sat_q       <= sat_d;
            ready_q     <= (state_d == RUN);
            filling_q   <= (state_d == FILL);
        end
    end

    // Next-state, pointer arithmetic and output staging.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        cur_delay_d = cur_delay_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sat_d       = 1'b0;

        // Wrapped read address; D = MAX_DELAY lands on wr_ptr and reads the old entry.
        rd_sum_c = (DW+1)'(wr_ptr_q) + MAX_W - (DW+1)'(cur_delay_q);
        if (rd_sum_c >= MAX_W) begin
            rd_sum_c = rd_sum_c - MAX_W;
        end
        rd_addr_c = AW'(rd_sum_c);

        cfg_clamp_c = (cfg_delay_i > MAX_D) ? MAX_D : cfg_delay_i;
        accept_c    = cfg_valid_i && (state_q == RUN);

        if (src_valid_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end

        case (state_q)
            FILL: begin
                if (src_valid_i) begin
                    if (fill_cnt_q == cur_delay_q - DW'(1)) begin
                        state_d    = RUN;
                        fill_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + DW'(1);
                    end
                end
            end
            RUN: begin
                if (src_valid_i) begin
                    valid_d = 1'b1;
                    data_d  = (cur_delay_q == '0) ? src_data_i : mem[rd_addr_c];
                end
                if (accept_c) begin
                    cur_delay_d = cfg_clamp_c;
                    sat_d       = (cfg_delay_i > MAX_D);
                    fill_cnt_d  = '0;
                    state_d     = (cfg_clamp_c == '0) ? RUN : FILL;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign cfg_ready_o   = ready_q;
    assign delay_data_o  = data_q;
    assign delay_valid_o = valid_q;
    assign cur_delay_o   = cur_delay_q;
    assign filling_o     = filling_q;
    assign cfg_sat_o     = sat_q;

endmodule

// File: tb/tb_fir_delay_ctrl.sv
// Directed + randomized bench for fir_delay_ctrl against a sample-history reference model.
module tb_fir_delay_ctrl;

    localparam int unsigned DWID = 16;
    localparam int unsigned MAXD = 64;
    localparam int unsigned DEFD = 8;
    localparam int unsigned CW   = $clog2(MAXD + 1);

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic [DWID-1:0] src_data_i = '0;
    logic            src_valid_i = 1'b0;
    logic [CW-1:0]   cfg_delay_i = '0;
    logic            cfg_valid_i = 1'b0;
    logic            cfg_ready_o;
    logic [DWID-1:0] delay_data_o;
    logic            delay_valid_o;
    logic [CW-1:0]   cur_delay_o;
    logic            filling_o;
    logic            cfg_sat_o;

    fir_delay_ctrl #(
        .DATA_WIDTH   (DWID),
        .MAX_DELAY    (MAXD),
        .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .src_data_i   (src_data_i),
        .src_valid_i  (src_valid_i),
        .cfg_delay_i  (cfg_delay_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .delay_data_o (delay_data_o),
        .delay_valid_o(delay_valid_o),
        .cur_delay_o  (cur_delay_o),
        .filling_o    (filling_o),
        .cfg_sat_o    (cfg_sat_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    // Model: active delay, inputs still to be absorbed, samples seen since reset.
    int              d_m;
    int              fill_rem;
    logic [DWID-1:0] hist[$];
    logic [DWID-1:0] ramp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_dut();
        rst_n_i     = 1'b0;
        src_valid_i = 1'b0;
        cfg_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        hist.delete();
        d_m      = DEFD;
        fill_rem = DEFD;
        chk("rst_valid", 32'(delay_valid_o), 32'(0));
        chk("rst_data", 32'(delay_data_o), 32'(0));
        chk("rst_sat", 32'(cfg_sat_o), 32'(0));
        chk("rst_cur_delay", 32'(cur_delay_o), 32'(DEFD));
        chk("rst_ready", 32'(cfg_ready_o), 32'(0));
        chk("rst_filling", 32'(filling_o), 32'(1));
        rst_n_i = 1'b1;
    endtask

    task automatic step(input bit sv, input logic [DWID-1:0] sd, input bit cv, input int cd);
        bit              acc;
        bit              ev;
        bit              esat;
        logic [DWID-1:0] ed;
        acc  = cv && (fill_rem == 0);
        ev   = 1'b0;
        esat = 1'b0;
        ed   = '0;
        if (sv) begin
            if (fill_rem > 0) begin
                fill_rem--;
            end else begin
                ev = 1'b1;
                ed = (d_m == 0) ? sd : hist[hist.size() - d_m];
            end
            hist.push_back(sd);
            if (hist.size() > 200) void'(hist.pop_front());
        end
        if (acc) begin
            esat     = (cd > int'(MAXD));
            d_m      = (cd > int'(MAXD)) ? int'(MAXD) : cd;
            fill_rem = d_m;
        end
        src_valid_i = sv;
        src_data_i  = sd;
        cfg_valid_i = cv;
        cfg_delay_i = CW'(cd);
        @(posedge clk_i);
        #1;
        chk("valid", 32'(delay_valid_o), 32'(ev));
        if (ev) chk("data", 32'(delay_data_o), 32'(ed));
        chk("cur_delay", 32'(cur_delay_o), 32'(d_m));
        chk("ready", 32'(cfg_ready_o), 32'(fill_rem == 0));
        chk("filling", 32'(filling_o), 32'(fill_rem > 0));
        chk("sat", 32'(cfg_sat_o), 32'(esat));
    endtask

    initial begin
        bit got;
        // Reset, default delay, continuous ramp
        reset_dut();
        ramp = 16'd1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        // Shrink to 3 with the ramp running
        step(1'b1, ramp, 1'b1, 3); ramp++;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        // Full depth across several pointer wraps, then a saturating request
        step(1'b1, ramp, 1'b1, int'(MAXD)); ramp++;
        for (int i = 0; i < 3 * int'(MAXD) + 10; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        step(1'b1, ramp, 1'b1, 100); ramp++;
        for (int i = 0; i < 70; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        // Zero delay passthrough with gaps
        step(1'b1, ramp, 1'b1, 0); ramp++;
        for (int i = 0; i < 20; i++) begin
            step(i % 4 != 3, ramp, 1'b0, 0); ramp++;
        end
        // Sparse input, D=5
        step(1'b1, ramp, 1'b1, 5); ramp++;
        for (int i = 0; i < 60; i++) begin
            step(i % 3 == 0, 16'($urandom), 1'b0, 0);
        end
        // Reset mid-fill, then a request held through the fill
        step(1'b1, ramp, 1'b1, 10); ramp++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            got = (fill_rem == 0);
            step(1'b1, ramp, 1'b1, 7); ramp++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, ramp, 1'b0, 0); ramp++;
        end
        // Random traffic and reconfiguration
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 127)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
